// File: rtl/rf_wb_arbiter.sv
// Purpose : write-port controller for the 32x32 register file; round-robin
//           arbitration of two writeback requesters plus a pending-write scoreboard.
// Latency : one cycle from a request handshake to rf_wen/rf_waddr/rf_wdata.
// Backpressure: the output stage drains every cycle, so a sole valid requester is
//           always granted; under contention the loser waits while the winner is granted.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   alloc_valid/addr/ready        destination-register reservation from issue
//   chk_addr1/2 -> busy1/2        hazard lookup of source registers (combinational)
//   reqN_valid/addr/data/ready    writeback requesters (0 = ALU, 1 = memory)
//   rf_wen/rf_waddr/rf_wdata      registered register-file write port
//   err                           sticky protocol error (write without reservation,
//                                 or both requesters targeting the same register)
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  alloc_ready,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  err
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  rr_ptr_q, rr_ptr_d;   // 0: requester 0 favoured
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  err_q, err_d;

  logic                  grant0, grant1, grant_any;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  clr_hit;
  logic                  same_addr_clash;

  always_comb begin
    // Arbitration: a lone requester always wins; the pointer breaks ties.
    grant0    = req0_valid && (!req1_valid || !rr_ptr_q);
    grant1    = req1_valid && (!req0_valid ||  rr_ptr_q);
    grant_any = grant0 || grant1;
    gnt_addr  = grant1 ? req1_addr : req0_addr;
    gnt_data  = grant1 ? req1_data : req0_data;

    req0_ready = grant0;
    req1_ready = grant1;

    busy1 = busy_q[chk_addr1];
    busy2 = busy_q[chk_addr2];

    // Refuse a reservation whose bit is being cleared by this cycle's write,
    // so a set and a clear never land on the same bit at the same edge. This
    // matters even when the bit is already clear (unreserved write in flight).
    clr_hit     = rf_wen_q && (rf_waddr_q == alloc_addr);
    alloc_ready = alloc_valid &&
                  ((alloc_addr == '0) || (!busy_q[alloc_addr] && !clr_hit));

    same_addr_clash = req0_valid && req1_valid &&
                      (req0_addr == req1_addr) && (req0_addr != '0);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant0) rr_ptr_d = 1'b1;
    if (grant1) rr_ptr_d = 1'b0;

    // Address 0 is granted (the requester is released) but never written.
    rf_wen_d   = grant_any && (gnt_addr != '0);
    rf_waddr_d = grant_any ? gnt_addr : rf_waddr_q;
    rf_wdata_d = grant_any ? gnt_data : rf_wdata_q;

    // Clear lands on the same edge as the register-file write.
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (alloc_ready && (alloc_addr != '0)) busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;

    err_d = err_q;
    if (grant_any && (gnt_addr != '0) && !busy_q[gnt_addr]) err_d = 1'b1;
    if (same_addr_clash) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rr_ptr_q   <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose : self-checking bench for rf_wb_arbiter (directed table, corner
//           sequences, random traffic against a behavioural model).
// Latency : model tracks the one-cycle output stage.
// Backpressure: model decides grants from the round-robin rules.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        alloc_ready;
  logic [4:0]  chk_addr1, chk_addr2;
  logic        busy1, busy2;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .busy1(busy1), .busy2(busy2),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_busy [32];
  bit          m_ptr_req1;     // requester 1 wins the next tie
  bit          m_wen, m_err, m_known;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic int winner();
    if (req0_valid && req1_valid) return m_ptr_req1 ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_alloc_ready();
    if (!alloc_valid) return 1'b0;
    if (alloc_addr == 5'd0) return 1'b1;
    return !m_busy[alloc_addr] && !(m_wen && m_waddr == alloc_addr);
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ptr_req1 = 1'b0;
    m_wen = 1'b0; m_err = 1'b0; m_known = 1'b1;
    m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_check();
    int w;
    w = winner();
    chk("req0_ready", req0_ready, (w == 0));
    chk("req1_ready", req1_ready, (w == 1));
    chk("alloc_ready", alloc_ready, exp_alloc_ready());
    chk("busy1", busy1, m_busy[chk_addr1]);
    chk("busy2", busy2, m_busy[chk_addr2]);
    chk("rf_wen", rf_wen, m_wen);
    chk("err", err, m_err);
    if (m_known) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
  endtask

  task automatic model_step();
    int w;
    bit ar;
    logic [4:0]  ga;
    logic [31:0] gd;
    if (rst) begin
      model_reset();
      return;
    end
    w  = winner();
    ar = exp_alloc_ready();
    ga = (w == 1) ? req1_addr : req0_addr;
    gd = (w == 1) ? req1_data : req0_data;
    if (w >= 0 && ga != 0 && !m_busy[ga]) m_err = 1'b1;
    if (req0_valid && req1_valid && req0_addr == req1_addr && req0_addr != 0) m_err = 1'b1;
    if (m_wen) m_busy[m_waddr] = 1'b0;
    if (ar && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    m_wen = (w >= 0) && (ga != 0);
    if (w >= 0) begin
      // Hold value after an address-0 grant is not pinned down; skip it.
      m_known = (ga != 0);
      m_waddr = ga;
      m_wdata = gd;
      m_ptr_req1 = (w == 0);
    end
  endtask

  task automatic tick_check();
    #3;
    model_check();
  endtask

  task automatic tick_adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; alloc_valid = 1'b0; alloc_addr = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; bit av; logic [4:0] aa; logic [4:0] c1;
    bit v0; logic [4:0] a0; logic [31:0] d0;
    bit v1; logic [4:0] a1; logic [31:0] d1;
    bit r0r; bit r1r; bit ar; bit b1; bit wen;
    bit ckd; logic [4:0] wa; logic [31:0] wd; bit err;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // rst av aa c1 | v0 a0 d0 | v1 a1 d1 | r0r r1r ar b1 wen | ckd wa wd err
    tbl[0]  = '{0,1,5,5, 0,0,0,            0,0,0,            0,0,1,0,0, 1,0,0,0};
    tbl[1]  = '{0,0,0,5, 1,5,32'hDEADBEEF, 0,0,0,            1,0,0,1,0, 1,0,0,0};
    tbl[2]  = '{0,0,0,5, 0,0,0,            0,0,0,            0,0,0,1,1, 1,5,32'hDEADBEEF,0};
    tbl[3]  = '{0,0,0,5, 0,0,0,            0,0,0,            0,0,0,0,0, 1,5,32'hDEADBEEF,0};
    tbl[4]  = '{1,0,0,5, 0,0,0,            0,0,0,            0,0,0,0,0, 1,5,32'hDEADBEEF,0};
    tbl[5]  = '{0,1,3,3, 0,0,0,            0,0,0,            0,0,1,0,0, 1,0,0,0};
    tbl[6]  = '{0,1,4,3, 0,0,0,            0,0,0,            0,0,1,1,0, 1,0,0,0};
    tbl[7]  = '{0,0,0,4, 1,3,32'h100,      1,4,32'h200,      1,0,0,1,0, 1,0,0,0};
    tbl[8]  = '{0,0,0,3, 1,3,32'h101,      1,4,32'h201,      0,1,0,1,1, 1,3,32'h100,0};
    tbl[9]  = '{0,0,0,3, 1,3,32'h102,      1,4,32'h202,      1,0,0,0,1, 1,4,32'h201,0};
    tbl[10] = '{0,0,0,4, 1,3,32'h103,      1,4,32'h203,      0,1,0,0,1, 1,3,32'h102,1};
    tbl[11] = '{0,0,0,0, 0,0,0,            0,0,0,            0,0,0,0,1, 1,4,32'h203,1};
    tbl[12] = '{1,0,0,0, 0,0,0,            0,0,0,            0,0,0,0,0, 1,4,32'h203,1};
    tbl[13] = '{0,0,0,0, 0,0,0,            1,0,32'h12345678, 0,1,0,0,0, 1,0,0,0};
    tbl[14] = '{0,1,0,0, 0,0,0,            0,0,0,            0,0,1,0,0, 0,0,0,0};
    tbl[15] = '{0,0,0,9, 1,9,32'h99,       0,0,0,            1,0,0,0,0, 0,0,0,0};
    tbl[16] = '{0,0,0,9, 0,0,0,            0,0,0,            0,0,0,0,1, 1,9,32'h99,1};
    tbl[17] = '{0,0,0,9, 0,0,0,            0,0,0,            0,0,0,0,0, 1,9,32'h99,1};
  end

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; alloc_valid = tbl[i].av; alloc_addr = tbl[i].aa;
      chk_addr1 = tbl[i].c1; chk_addr2 = '0;
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
      tick_check();
      chk($sformatf("tbl%0d req0_ready", i), req0_ready, tbl[i].r0r);
      chk($sformatf("tbl%0d req1_ready", i), req1_ready, tbl[i].r1r);
      chk($sformatf("tbl%0d alloc_ready", i), alloc_ready, tbl[i].ar);
      chk($sformatf("tbl%0d busy1", i), busy1, tbl[i].b1);
      chk($sformatf("tbl%0d rf_wen", i), rf_wen, tbl[i].wen);
      chk($sformatf("tbl%0d err", i), err, tbl[i].err);
      if (tbl[i].ckd) begin
        chk($sformatf("tbl%0d rf_waddr", i), rf_waddr, tbl[i].wa);
        chk($sformatf("tbl%0d rf_wdata", i), rf_wdata, tbl[i].wd);
      end
      tick_adv();
    end

    // ---- held alloc to a busy register, and alloc of r0 ----
    set_idle(); rst = 1'b1; tick_check(); tick_adv();
    set_idle(); alloc_valid = 1'b1; alloc_addr = 5'd7;
    tick_check(); chk("hold first alloc_ready", alloc_ready, 1'b1); tick_adv();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77; chk_addr1 = 5'd7;
    tick_check(); chk("hold grant alloc_ready", alloc_ready, 1'b0);
    chk("hold grant busy1", busy1, 1'b1); tick_adv();
    req0_valid = 1'b0;
    tick_check(); chk("hold wen cycle rf_wen", rf_wen, 1'b1);
    chk("hold wen cycle alloc_ready", alloc_ready, 1'b0); tick_adv();
    tick_check(); chk("hold after alloc_ready", alloc_ready, 1'b1);
    chk("hold after busy1", busy1, 1'b0); tick_adv();
    alloc_addr = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd7;
    tick_check(); chk("alloc r0 alloc_ready", alloc_ready, 1'b1);
    chk("alloc r0 busy2", busy2, 1'b1); tick_adv();
    alloc_valid = 1'b0;
    tick_check(); chk("alloc r0 after busy1", busy1, 1'b0);
    chk("alloc r0 after busy2", busy2, 1'b1); tick_adv();

    // ---- reset with a busy register and a write in the output stage ----
    set_idle(); alloc_valid = 1'b1; alloc_addr = 5'd2; tick_check(); tick_adv();
    set_idle(); req0_valid = 1'b1; req0_addr = 5'd11; req0_data = 32'hB;
    tick_check(); tick_adv();
    req0_addr = 5'd2; req0_data = 32'h2222; tick_check(); tick_adv();
    set_idle(); rst = 1'b1; chk_addr1 = 5'd2;
    tick_check(); chk("prerst rf_wen", rf_wen, 1'b1); chk("prerst busy1", busy1, 1'b1);
    chk("prerst err", err, 1'b1); tick_adv();
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA1;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hB6;
    tick_check(); chk("postrst rf_wen", rf_wen, 1'b0); chk("postrst busy1", busy1, 1'b0);
    chk("postrst err", err, 1'b0); chk("postrst req0_ready", req0_ready, 1'b1);
    chk("postrst req1_ready", req1_ready, 1'b0); tick_adv();

    // ---- random traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      alloc_valid = $urandom_range(0, 1);
      alloc_addr  = 5'($urandom_range(0, 7));
      chk_addr1   = 5'($urandom_range(0, 7));
      chk_addr2   = 5'($urandom_range(0, 7));
      req0_valid  = ($urandom_range(0, 2) != 0);
      req0_addr   = 5'($urandom_range(0, 7));
      req0_data   = $urandom;
      req1_valid  = ($urandom_range(0, 2) != 0);
      req1_addr   = 5'($urandom_range(0, 7));
      req1_data   = $urandom;
      tick_check();
      tick_adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
